// File: rtl/cordic_rotation_if.sv
// Handshake bundle for cordic_rotation: magnitude/phase request channel
// and the x/y result channel, each with its own valid/ready pair.
interface cordic_rotation_if #(
  parameter int WORD_WIDTH  = 16,
  parameter int PHASE_WIDTH = 16
) ();
  logic                          in_valid;
  logic                          in_ready;
  logic signed [WORD_WIDTH-1:0]  mag_in;
  logic signed [PHASE_WIDTH-1:0] phase_in;
  logic                          out_valid;
  logic                          out_ready;
  logic signed [WORD_WIDTH:0]    x_out;
  logic signed [WORD_WIDTH:0]    y_out;

  modport master (
    output in_valid, mag_in, phase_in, out_ready,
    input  in_ready, out_valid, x_out, y_out
  );

  modport slave (
    input  in_valid, mag_in, phase_in, out_ready,
    output in_ready, out_valid, x_out, y_out
  );
endinterface

// File: rtl/cordic_rotation.sv
// Iterative rotation-mode CORDIC: magnitude + phase (degrees x128) to x/y, one
// micro-rotation per clock. Define CORDIC_GAIN_COMP_EN to add a gain-compensation cycle.
module cordic_rotation #(
  parameter int WORD_WIDTH  = 16,
  parameter int PHASE_WIDTH = 16,
  parameter int ITERATIONS  = 16
) (
  input logic              clk,
  input logic              rst,
  cordic_rotation_if.slave bus
);

  localparam int XW = WORD_WIDTH + 2;

  localparam logic signed [PHASE_WIDTH-1:0] PHASE_90  = PHASE_WIDTH'(11520);
  localparam logic signed [PHASE_WIDTH-1:0] PHASE_180 = PHASE_WIDTH'(23040);
  localparam logic [4:0]                    LAST_ITER = 5'(ITERATIONS - 1);

  localparam int ATAN_DEG128 [16] = '{5760, 3400, 1797, 912, 458, 229, 115, 57,
                                      29, 14, 7, 4, 2, 1, 0, 0};

`ifdef CORDIC_GAIN_COMP_EN
  typedef enum logic [1:0] {IDLE, ROTATE, COMP, DONE} state_t;

  localparam logic signed [XW-1:0] SAT_MAX = {3'b000, {(WORD_WIDTH-1){1'b1}}};
  localparam logic signed [XW-1:0] SAT_MIN = {3'b111, {(WORD_WIDTH-1){1'b0}}};

  // Shift-add approximation of 1/1.6468 applied to the raw CORDIC output.
  function automatic logic signed [XW-1:0] gain_k(input logic signed [XW-1:0] v);
    return (v >>> 1) + (v >>> 3) - (v >>> 6) - (v >>> 9) - (v >>> 13);
  endfunction

  function automatic logic signed [WORD_WIDTH:0] sat_word(input logic signed [XW-1:0] v);
    logic signed [XW-1:0] s;
    s = v;
    if (v > SAT_MAX) begin
      s = SAT_MAX;
    end else if (v < SAT_MIN) begin
      s = SAT_MIN;
    end
    return s[WORD_WIDTH:0];
  endfunction
`else
  typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_t;
`endif

  state_t state;

  logic signed [XW-1:0]          x_reg, y_reg;
  logic signed [PHASE_WIDTH-1:0] z_reg;
  logic [4:0]                    i_reg;

  logic signed [XW-1:0]          x_next, y_next, x_shift, y_shift;
  logic signed [PHASE_WIDTH-1:0] z_next, atan_cur;
  logic signed [XW-1:0]          x_init, mag_ext;
  logic signed [PHASE_WIDTH-1:0] z_init;

  logic                          in_ready_reg, out_valid_reg;
  logic signed [WORD_WIDTH:0]    x_out_reg, y_out_reg;

  logic signed [PHASE_WIDTH-1:0] atan_tab [16];

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_atan
      assign atan_tab[gi] = PHASE_WIDTH'(ATAN_DEG128[gi]);
    end
  endgenerate

  assign atan_cur = atan_tab[i_reg[3:0]];

  // Fold phases beyond +/-90 deg into the convergence range by negating x0.
  always_comb begin
    mag_ext = {{2{bus.mag_in[WORD_WIDTH-1]}}, bus.mag_in};
    z_init  = bus.phase_in;
    x_init  = mag_ext;
    if (bus.phase_in > PHASE_90) begin
      z_init = bus.phase_in - PHASE_180;
      x_init = -mag_ext;
    end else if (bus.phase_in < -PHASE_90) begin
      z_init = bus.phase_in + PHASE_180;
      x_init = -mag_ext;
    end
  end

  always_comb begin
    x_shift = x_reg >>> i_reg;
    y_shift = y_reg >>> i_reg;
    if (!z_reg[PHASE_WIDTH-1]) begin
      x_next = x_reg - y_shift;
      y_next = y_reg + x_shift;
      z_next = z_reg - atan_cur;
    end else begin
      x_next = x_reg + y_shift;
      y_next = y_reg - x_shift;
      z_next = z_reg + atan_cur;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      x_out_reg     <= '0;
      y_out_reg     <= '0;
      x_reg         <= '0;
      y_reg         <= '0;
      z_reg         <= '0;
      i_reg         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            x_reg        <= x_init;
            y_reg        <= '0;
            z_reg        <= z_init;
            i_reg        <= '0;
            in_ready_reg <= 1'b0;
            state        <= ROTATE;
          end
        end

        ROTATE: begin
          x_reg <= x_next;
          y_reg <= y_next;
          z_reg <= z_next;
          i_reg <= i_reg + 5'd1;
          if (i_reg == LAST_ITER) begin
`ifdef CORDIC_GAIN_COMP_EN
            state <= COMP;
`else
            x_out_reg     <= x_next[WORD_WIDTH:0];
            y_out_reg     <= y_next[WORD_WIDTH:0];
            out_valid_reg <= 1'b1;
            state         <= DONE;
`endif
          end
        end

`ifdef CORDIC_GAIN_COMP_EN
        COMP: begin
          x_out_reg     <= sat_word(gain_k(x_reg));
          y_out_reg     <= sat_word(gain_k(y_reg));
          out_valid_reg <= 1'b1;
          state         <= DONE;
        end
`endif

        DONE: begin
          // Result is held until taken; IDLE is re-entered with in_ready registered high.
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state         <= IDLE;
          end
        end

        default: begin
          state         <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.x_out     = x_out_reg;
  assign bus.y_out     = y_out_reg;

endmodule

// File: tb/tb_cordic_rotation.sv
// Directed-vector bench for cordic_rotation; expected x/y are hand-computed
// mag*cos/sin values (raw gain 1.6468 applied when gain compensation is off).
module tb_cordic_rotation;

  localparam int W = 16;
  localparam int P = 16;
  localparam int N = 16;

`ifdef CORDIC_GAIN_COMP_EN
  localparam bit COMP_ON = 1'b1;
  localparam int LAT     = N + 1;
`else
  localparam bit COMP_ON = 1'b0;
  localparam int LAT     = N;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cordic_rotation_if #(.WORD_WIDTH(W), .PHASE_WIDTH(P)) bus ();

  cordic_rotation #(.WORD_WIDTH(W), .PHASE_WIDTH(P), .ITERATIONS(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int mag;
    int ph;
    int cx;
    int cy;
    int rx;
    int ry;
    int tol;
  } vec_t;

  // cx/cy: gain-compensated; rx/ry: raw (x1.64676)
  vec_t vecs [7] = '{
    '{1000,      0,  1000,     0,  1647,     0, 6},
    '{1000,  11520,     0,  1000,     0,  1647, 6},
    '{1000, -17280,  -707,  -707, -1164, -1164, 6},
    '{1000,  23039, -1000,     0, -1647,     0, 6},
    '{1000,   5760,   707,   707,  1164,  1164, 6},
    '{1000,  -5760,   707,  -707,  1164, -1164, 6},
    '{32767,  5760, 23170, 23170, 38155, 38155, 12}
  };

  task automatic check(input string tag, input int got, input int exp, input int tol);
    total++;
    if (got > exp + tol || got < exp - tol) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d tol=%0d", tag, got, exp, tol);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int mag, input int ph);
    bus.mag_in   = W'(mag);
    bus.phase_in = P'(ph);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < 100) begin
      step();
      cyc++;
    end
  endtask

  task automatic run_vec(input int k, input bit hold);
    int cyc;
    int ex, ey;
    ex = COMP_ON ? vecs[k].cx : vecs[k].rx;
    ey = COMP_ON ? vecs[k].cy : vecs[k].ry;
    check($sformatf("v%0d_in_ready_idle", k), int'(bus.in_ready), 1, 0);
    send(vecs[k].mag, vecs[k].ph);
    check($sformatf("v%0d_in_ready_busy", k), int'(bus.in_ready), 0, 0);
    wait_out(cyc);
    check($sformatf("v%0d_latency", k), cyc, LAT, 0);
    check($sformatf("v%0d_x", k), int'(bus.x_out), ex, vecs[k].tol);
    check($sformatf("v%0d_y", k), int'(bus.y_out), ey, vecs[k].tol);
    $display("txn mag=%0d phase=%0d x=%0d y=%0d latency=%0d",
             vecs[k].mag, vecs[k].ph, bus.x_out, bus.y_out, cyc);
    if (hold) begin
      for (int c = 0; c < 5; c++) begin
        bus.mag_in   = W'(500);
        bus.phase_in = P'(0);
        bus.in_valid = (c % 2 == 0);
        step();
        check($sformatf("bp%0d_out_valid", c), int'(bus.out_valid), 1, 0);
        check($sformatf("bp%0d_in_ready", c), int'(bus.in_ready), 0, 0);
        check($sformatf("bp%0d_x", c), int'(bus.x_out), ex, vecs[k].tol);
        check($sformatf("bp%0d_y", c), int'(bus.y_out), ey, vecs[k].tol);
      end
      bus.in_valid = 1'b0;
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check($sformatf("v%0d_in_ready_after", k), int'(bus.in_ready), 1, 0);
    check($sformatf("v%0d_out_valid_after", k), int'(bus.out_valid), 0, 0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.mag_in    = '0;
    bus.phase_in  = '0;
    rst = 1'b1;
    step();
    step();
    check("rst_in_ready", int'(bus.in_ready), 1, 0);
    check("rst_out_valid", int'(bus.out_valid), 0, 0);
    check("rst_x", int'(bus.x_out), 0, 0);
    check("rst_y", int'(bus.y_out), 0, 0);
    rst = 1'b0;
    step();

    for (int k = 0; k < 7; k++) begin
      run_vec(k, k == 4);
    end

    // Pulses ignored during backpressure must not have started a new job.
    for (int c = 0; c < LAT + 4; c++) step();
    check("bp_no_phantom_job", int'(bus.out_valid), 0, 0);

    // Reset in the middle of rotation aborts the job.
    send(1000, 11520);
    for (int c = 0; c < 7; c++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_in_ready", int'(bus.in_ready), 1, 0);
    check("midrst_out_valid", int'(bus.out_valid), 0, 0);
    check("midrst_x", int'(bus.x_out), 0, 0);
    check("midrst_y", int'(bus.y_out), 0, 0);
    for (int c = 0; c < LAT + 4; c++) step();
    check("midrst_no_result", int'(bus.out_valid), 0, 0);
    run_vec(0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
